aes_128_req_arb: RTL and testbench

Two-requester arbiter and tag tracker for the shared AES-128 encryption core. It accepts 128-bit blocks from two independent requester channels and issues them one per cycle to the core. Each block carries a key-set select, so the core uses one of the two loaded key sets. Results return from the core in issue order and are routed back to the requester that issued them. The block sits between the requester front ends and the AES-128 top, with a credit limit that prevents in-flight overflow.

---
 rtl/aes_128_req_arb.sv | 108 ++++++++++
 tb/tb_aes_128_req_arb.sv | 312 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/aes_128_req_arb.sv
// aes_128_req_arb: round-robin arbiter for two requesters sharing one AES-128 core.
// Issues one block per cycle under a credit limit and routes in-order results back by tag.
module aes_128_req_arb #(
   parameter int DATA_W       = 128,
   parameter int MAX_INFLIGHT = 16,
   localparam int AW          = $clog2(MAX_INFLIGHT),
   localparam int CW          = AW + 1
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              req0_valid,
   output logic              req0_ready,
   input  logic [DATA_W-1:0] req0_data,
   input  logic              req0_key_sel,
   input  logic              req1_valid,
   output logic              req1_ready,
   input  logic [DATA_W-1:0] req1_data,
   input  logic              req1_key_sel,
   output logic              core_valid_o,
   output logic [DATA_W-1:0] core_data_o,
   output logic              core_key_sel_o,
   input  logic              core_valid_i,
   input  logic [DATA_W-1:0] core_data_i,
   output logic              rsp0_valid,
   output logic [DATA_W-1:0] rsp0_data,
   output logic              rsp1_valid,
   output logic [DATA_W-1:0] rsp1_data,
   output logic [CW-1:0]     inflight_cnt,
   output logic              busy,
   output logic              err_orphan
);
   logic                    last_q, last_d;
   logic [CW-1:0]           cnt_q, cnt_d;
   logic [AW-1:0]           wr_q, wr_d, rd_q, rd_d;
   logic [MAX_INFLIGHT-1:0] tags_q, tags_d;
   logic                    cv_q, cv_d, ck_q, ck_d;
   logic [DATA_W-1:0]       cd_q, cd_d, r0d_q, r0d_d, r1d_q, r1d_d;
   logic                    r0v_q, r0v_d, r1v_q, r1v_d, err_q, err_d;
   logic                    winner, credit_ok, accept, pop, tag;

   always_comb begin
      // with no requester valid the pointer still picks a winner so ready never waits on valid
      winner    = (req0_valid & req1_valid) ? ~last_q : req1_valid ? 1'b1 : req0_valid ? 1'b0 : ~last_q;
      credit_ok = (cnt_q < CW'(MAX_INFLIGHT)) | core_valid_i;
      accept    = (winner ? req1_valid : req0_valid) & credit_ok;
      pop       = core_valid_i & (cnt_q != '0);
      tag       = tags_q[rd_q];
      last_d    = accept ? winner : last_q;
      tags_d    = tags_q;
      if (accept) tags_d[wr_q] = winner;
      wr_d      = accept ? wr_q + 1'b1 : wr_q;
      rd_d      = pop ? rd_q + 1'b1 : rd_q;
      cnt_d     = cnt_q + CW'(accept) - CW'(pop);
      cv_d      = accept;
      cd_d      = accept ? (winner ? req1_data : req0_data) : cd_q;
      ck_d      = accept ? (winner ? req1_key_sel : req0_key_sel) : ck_q;
      r0v_d     = pop & ~tag;
      r1v_d     = pop & tag;
      r0d_d     = r0v_d ? core_data_i : r0d_q;
      r1d_d     = r1v_d ? core_data_i : r1d_q;
      err_d     = err_q | (core_valid_i & (cnt_q == '0));
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         last_q <= 1'b1;
         cnt_q  <= '0;
         wr_q   <= '0;
         rd_q   <= '0;
         tags_q <= '0;
         cv_q   <= 1'b0;
         cd_q   <= '0;
         ck_q   <= 1'b0;
         r0v_q  <= 1'b0;
         r1v_q  <= 1'b0;
         r0d_q  <= '0;
         r1d_q  <= '0;
         err_q  <= 1'b0;
      end else begin
         last_q <= last_d;
         cnt_q  <= cnt_d;
         wr_q   <= wr_d;
         rd_q   <= rd_d;
         tags_q <= tags_d;
         cv_q   <= cv_d;
         cd_q   <= cd_d;
         ck_q   <= ck_d;
         r0v_q  <= r0v_d;
         r1v_q  <= r1v_d;
         r0d_q  <= r0d_d;
         r1d_q  <= r1d_d;
         err_q  <= err_d;
      end
   end

   assign req0_ready     = ~winner & credit_ok;
   assign req1_ready     = winner & credit_ok;
   assign core_valid_o   = cv_q;
   assign core_data_o    = cd_q;
   assign core_key_sel_o = ck_q;
   assign rsp0_valid     = r0v_q;
   assign rsp1_valid     = r1v_q;
   assign rsp0_data      = r0d_q;
   assign rsp1_data      = r1d_q;
   assign inflight_cnt   = cnt_q;
   assign busy           = (cnt_q != '0) | cv_q;
   assign err_orphan     = err_q;
endmodule

// File: tb/tb_aes_128_req_arb.sv
// tb_aes_128_req_arb: scenario tasks driving the arbiter against a queue-based reference model.
module tb_aes_128_req_arb;
   localparam int DW = 128;
   localparam int MI = 16;

   logic          clk = 1'b0, rst_n = 1'b0;
   logic          req0_valid = 1'b0, req1_valid = 1'b0, req0_key_sel = 1'b0, req1_key_sel = 1'b0;
   logic          core_valid_i = 1'b0;
   logic [DW-1:0] req0_data = '0, req1_data = '0, core_data_i = '0;
   logic          req0_ready, req1_ready, core_valid_o, core_key_sel_o;
   logic          rsp0_valid, rsp1_valid, busy, err_orphan;
   logic [DW-1:0] core_data_o, rsp0_data, rsp1_data;
   logic [4:0]    inflight_cnt;

   int errors = 0, checks = 0;
   bit m_last, m_err, m_cv, m_ck, m_r0v, m_r1v, g_w, g_acc;
   bit m_tags[$];
   logic [DW-1:0] m_cd, m_r0d, m_r1d;

   aes_128_req_arb #(.DATA_W(DW), .MAX_INFLIGHT(MI)) dut (
      .clk(clk), .rst_n(rst_n),
      .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_data(req0_data), .req0_key_sel(req0_key_sel),
      .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_data(req1_data), .req1_key_sel(req1_key_sel),
      .core_valid_o(core_valid_o), .core_data_o(core_data_o), .core_key_sel_o(core_key_sel_o),
      .core_valid_i(core_valid_i), .core_data_i(core_data_i),
      .rsp0_valid(rsp0_valid), .rsp0_data(rsp0_data), .rsp1_valid(rsp1_valid), .rsp1_data(rsp1_data),
      .inflight_cnt(inflight_cnt), .busy(busy), .err_orphan(err_orphan)
   );

   always #5 clk = ~clk;

   function automatic logic [DW-1:0] rnd128();
      return {$urandom, $urandom, $urandom, $urandom};
   endfunction

   task automatic model_reset();
      m_last = 1'b1;
      m_tags.delete();
      m_err = 0; m_cv = 0; m_ck = 0; m_r0v = 0; m_r1v = 0;
      m_cd = '0; m_r0d = '0; m_r1d = '0;
   endtask

   task automatic idle_inputs();
      req0_valid = 0; req1_valid = 0; core_valid_i = 0;
   endtask

   // Called at posedge+1 with inputs already applied; returns at the next posedge+1.
   task automatic cycle(input string tn);
      bit w, cr, t;
      #1;
      w  = (req0_valid && req1_valid) ? !m_last : req1_valid ? 1'b1 : req0_valid ? 1'b0 : !m_last;
      cr = (m_tags.size() < MI) || core_valid_i;
      checks++;
      if ({req0_ready, req1_ready} !== {!w && cr, w && cr}) begin
         errors++;
         $display("FAIL %s ready: got %b want %b", tn, {req0_ready, req1_ready}, {!w && cr, w && cr});
      end
      g_w = w;
      g_acc = (w ? req1_valid : req0_valid) && cr;
      m_r0v = 0; m_r1v = 0;
      if (core_valid_i) begin
         if (m_tags.size() == 0) m_err = 1;
         else begin
            t = m_tags.pop_front();
            if (t) begin m_r1v = 1; m_r1d = core_data_i; end
            else begin m_r0v = 1; m_r0d = core_data_i; end
         end
      end
      m_cv = g_acc;
      if (g_acc) begin
         m_tags.push_back(w);
         m_last = w;
         m_cd = w ? req1_data : req0_data;
         m_ck = w ? req1_key_sel : req0_key_sel;
      end
      @(posedge clk); #1;
      checks++;
      if ({core_valid_o, core_key_sel_o, rsp0_valid, rsp1_valid, busy, err_orphan} !==
          {m_cv, m_ck, m_r0v, m_r1v, (m_tags.size() != 0) || m_cv, m_err}) begin
         errors++;
         $display("FAIL %s ctrl(cv,key,r0v,r1v,busy,err): got %b want %b", tn,
                  {core_valid_o, core_key_sel_o, rsp0_valid, rsp1_valid, busy, err_orphan},
                  {m_cv, m_ck, m_r0v, m_r1v, (m_tags.size() != 0) || m_cv, m_err});
      end
      checks++;
      if (inflight_cnt !== 5'(m_tags.size())) begin
         errors++;
         $display("FAIL %s inflight_cnt: got %0d want %0d", tn, inflight_cnt, m_tags.size());
      end
      checks++;
      if (core_data_o !== m_cd) begin
         errors++;
         $display("FAIL %s core_data_o: got %h want %h", tn, core_data_o, m_cd);
      end
      checks++;
      if ({rsp0_data, rsp1_data} !== {m_r0d, m_r1d}) begin
         errors++;
         $display("FAIL %s rsp_data: got %h/%h want %h/%h", tn, rsp0_data, rsp1_data, m_r0d, m_r1d);
      end
   endtask

   task automatic apply_reset();
      idle_inputs();
      rst_n = 0;
      repeat (2) @(posedge clk);
      #1 rst_n = 1;
      model_reset();
   endtask

   task automatic test_reset();
      idle_inputs();
      rst_n = 0;
      repeat (2) @(posedge clk);
      #1;
      checks++;
      if ({req0_ready, req1_ready, core_valid_o, core_key_sel_o, rsp0_valid, rsp1_valid, busy, err_orphan} !== 8'b1000_0000) begin
         errors++;
         $display("FAIL reset ctrl: got %b want 10000000",
                  {req0_ready, req1_ready, core_valid_o, core_key_sel_o, rsp0_valid, rsp1_valid, busy, err_orphan});
      end
      checks++;
      if ({core_data_o, rsp0_data, rsp1_data, inflight_cnt} !== '0) begin
         errors++;
         $display("FAIL reset data/cnt: got %h/%h/%h/%0d want 0", core_data_o, rsp0_data, rsp1_data, inflight_cnt);
      end
      rst_n = 1;
      model_reset();
   endtask

   task automatic test_single();
      req0_valid = 1; req0_key_sel = 0; req0_data = 128'h00112233445566778899aabbccddeeff;
      cycle("single_issue");
      checks++;
      if ({core_valid_o, core_key_sel_o, inflight_cnt} !== {1'b1, 1'b0, 5'd1} || core_data_o !== 128'h00112233445566778899aabbccddeeff) begin
         errors++;
         $display("FAIL single_issue: got v=%b k=%b cnt=%0d d=%h want 1/0/1/00112233445566778899aabbccddeeff",
                  core_valid_o, core_key_sel_o, inflight_cnt, core_data_o);
      end
      req0_valid = 0;
      cycle("single_wait");
      core_valid_i = 1; core_data_i = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
      cycle("single_return");
      checks++;
      if ({rsp0_valid, rsp1_valid, inflight_cnt} !== {1'b1, 1'b0, 5'd0} || rsp0_data !== 128'h69c4e0d86a7b0430d8cdb78070b4c55a) begin
         errors++;
         $display("FAIL single_return: got r0v=%b r1v=%b cnt=%0d d=%h want 1/0/0/69c4e0d86a7b0430d8cdb78070b4c55a",
                  rsp0_valid, rsp1_valid, inflight_cnt, rsp0_data);
      end
      core_valid_i = 0;
      cycle("single_idle");
   endtask

   task automatic test_alternate();
      int due[$];
      apply_reset();
      for (int i = 0; i < 40; i++) begin
         req0_valid = (i < 8); req1_valid = (i < 8);
         req0_data = rnd128(); req1_data = rnd128();
         req0_key_sel = 1'($urandom); req1_key_sel = 1'($urandom);
         core_valid_i = (due.size() > 0) && (due[0] == i);
         if (core_valid_i) void'(due.pop_front());
         core_data_i = rnd128();
         cycle("alternate");
         if (i < 8) begin
            checks++;
            if (!g_acc || g_w !== 1'(i % 2)) begin
               errors++;
               $display("FAIL alternate grant %0d: got acc=%b id=%0d want acc=1 id=%0d", i, g_acc, g_w, i % 2);
            end
         end
         if (core_valid_o) due.push_back(i + 10);
      end
      checks++;
      if (inflight_cnt !== 5'd0) begin
         errors++;
         $display("FAIL alternate drain: got cnt=%0d want 0", inflight_cnt);
      end
   endtask

   task automatic test_credit_full();
      int n = 0;
      apply_reset();
      req0_valid = 1;
      for (int i = 0; i < 20; i++) begin
         req0_data = rnd128(); req0_key_sel = 1'($urandom);
         cycle("credit_fill");
         if (g_acc) n++;
      end
      checks++;
      if (n != 16 || req0_ready !== 1'b0 || inflight_cnt !== 5'd16) begin
         errors++;
         $display("FAIL credit_full: got accepts=%0d ready=%b cnt=%0d want 16/0/16", n, req0_ready, inflight_cnt);
      end
   endtask

   task automatic test_full_retire_wrap();
      core_valid_i = 1; req0_valid = 1;
      for (int i = 0; i < 24; i++) begin
         req0_data = rnd128(); core_data_i = rnd128();
         req1_valid = 1'($urandom); req1_data = rnd128();
         cycle("full_retire");
         checks++;
         if (!g_acc || inflight_cnt !== 5'd16) begin
            errors++;
            $display("FAIL full_retire %0d: got acc=%b cnt=%0d want 1/16", i, g_acc, inflight_cnt);
         end
      end
      req0_valid = 0; req1_valid = 0;
      for (int i = 0; i < 16; i++) begin
         core_data_i = rnd128();
         cycle("wrap_drain");
      end
      core_valid_i = 0;
      checks++;
      if (inflight_cnt !== 5'd0 || err_orphan !== 1'b0) begin
         errors++;
         $display("FAIL wrap_drain: got cnt=%0d err=%b want 0/0", inflight_cnt, err_orphan);
      end
   endtask

   task automatic test_orphan();
      idle_inputs();
      core_valid_i = 1; core_data_i = rnd128();
      cycle("orphan");
      core_valid_i = 0;
      checks++;
      if ({rsp0_valid, rsp1_valid, err_orphan, inflight_cnt} !== {1'b0, 1'b0, 1'b1, 5'd0}) begin
         errors++;
         $display("FAIL orphan: got r0v=%b r1v=%b err=%b cnt=%0d want 0/0/1/0", rsp0_valid, rsp1_valid, err_orphan, inflight_cnt);
      end
      repeat (3) cycle("orphan_hold");
      checks++;
      if (err_orphan !== 1'b1) begin
         errors++;
         $display("FAIL orphan_sticky: got err=%b want 1", err_orphan);
      end
   endtask

   task automatic test_random();
      apply_reset();
      for (int i = 0; i < 300; i++) begin
         req0_valid = ($urandom % 4) != 0; req1_valid = ($urandom % 3) != 0;
         req0_data = rnd128(); req1_data = rnd128();
         req0_key_sel = 1'($urandom); req1_key_sel = 1'($urandom);
         core_valid_i = ($urandom % 5) < 2; core_data_i = rnd128();
         cycle("random");
      end
      idle_inputs();
   endtask

   task automatic test_async_reset();
      apply_reset();
      req0_valid = 1;
      for (int i = 0; i < 6; i++) begin
         req0_data = rnd128(); req0_key_sel = 1'($urandom);
         cycle("async_fill");
      end
      req0_valid = 0; core_valid_i = 1; core_data_i = rnd128();
      cycle("async_ret");
      core_valid_i = 0;
      checks++;
      if (inflight_cnt !== 5'd5) begin
         errors++;
         $display("FAIL async_pre: got cnt=%0d want 5", inflight_cnt);
      end
      #3 rst_n = 0;
      #1;
      model_reset();
      checks++;
      if ({core_valid_o, core_key_sel_o, rsp0_valid, rsp1_valid, busy, err_orphan, inflight_cnt} !== '0 ||
          {core_data_o, rsp0_data, rsp1_data} !== '0) begin
         errors++;
         $display("FAIL async_reset: got cv=%b r0v=%b busy=%b cnt=%0d cd=%h r0d=%h want all 0",
                  core_valid_o, rsp0_valid, busy, inflight_cnt, core_data_o, rsp0_data);
      end
      @(posedge clk); #1 rst_n = 1;
      core_valid_i = 1; core_data_i = rnd128();
      cycle("async_orphan");
      core_valid_i = 0;
      checks++;
      if (err_orphan !== 1'b1 || rsp0_valid !== 1'b0) begin
         errors++;
         $display("FAIL async_orphan: got err=%b r0v=%b want 1/0", err_orphan, rsp0_valid);
      end
      req1_valid = 1; req1_data = rnd128(); req1_key_sel = 1;
      cycle("async_accept");
      req1_valid = 0;
      checks++;
      if (!g_acc || core_valid_o !== 1'b1 || inflight_cnt !== 5'd1) begin
         errors++;
         $display("FAIL async_accept: got acc=%b cv=%b cnt=%0d want 1/1/1", g_acc, core_valid_o, inflight_cnt);
      end
      core_valid_i = 1; core_data_i = rnd128();
      cycle("async_return");
      core_valid_i = 0;
      cycle("async_idle");
   endtask

   initial begin
      model_reset();
      test_reset();
      test_single();
      test_alternate();
      test_credit_full();
      test_full_retire_wrap();
      test_orphan();
      test_random();
      test_async_reset();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
